// File: rtl/time_set_controller_if.sv
// time_set_controller_if: raw set/change/add buttons in, datapath controls out.
// master = controller side, slave = button and datapath side.
interface time_set_controller_if;
  logic       set_time_button;
  logic       set_time_change_button;
  logic       set_time_add_button;
  logic       count_en;
  logic       hour_inc;
  logic       minute_inc;
  logic       second_inc;
  logic [1:0] mode;
  logic [5:0] blink_mask;

  modport master (
    input  set_time_button,
    input  set_time_change_button,
    input  set_time_add_button,
    output count_en,
    output hour_inc,
    output minute_inc,
    output second_inc,
    output mode,
    output blink_mask
  );

  modport slave (
    output set_time_button,
    output set_time_change_button,
    output set_time_add_button,
    input  count_en,
    input  hour_inc,
    input  minute_inc,
    input  second_inc,
    input  mode,
    input  blink_mask
  );
endinterface

// File: rtl/time_set_controller.sv
// time_set_controller: debounces set/change/add, runs the RUN/SET mode machine,
// issues hour/minute/second inc pulses (with auto-repeat) and the blink mask.
module time_set_controller #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ    = 2,
  parameter int HOLD_MS     = 1000,
  parameter int REPEAT_HZ   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  time_set_controller_if.master bus
);

  localparam int DB_N   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HOLD_N = CLK_FREQ / 1000 * HOLD_MS;
  localparam int REP_N  = CLK_FREQ / REPEAT_HZ;
  localparam int HALF_N = CLK_FREQ / (2 * BLINK_HZ);

  localparam int DB_W   = (DB_N > 1) ? $clog2(DB_N) : 1;
  localparam int HOLD_W = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
  localparam int REP_W  = (REP_N > 1) ? $clog2(REP_N) : 1;
  localparam int HALF_W = (HALF_N > 1) ? $clog2(HALF_N) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_N - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_N - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_N - 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HOUR = 2'd1;
  localparam logic [1:0] S_MIN  = 2'd2;
  localparam logic [1:0] S_SEC  = 2'd3;

  // bit 0 set, bit 1 change, bit 2 add
  logic [2:0]      raw;
  logic [2:0]      s1;
  logic [2:0]      s2;
  logic [2:0]      deb;
  logic [2:0]      deb_q;
  logic [2:0]      press;
  logic [DB_W-1:0] dcnt [3];

  assign raw = {bus.set_time_add_button,
                bus.set_time_change_button,
                bus.set_time_button};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '1;
      s2    <= '1;
      deb   <= '1;
      deb_q <= '1;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DB_W'(1);
        end
      end
    end
  end

  // press = debounced falling edge, one cycle
  assign press = deb_q & ~deb;

  logic set_p;
  logic chg_p;
  logic add_p;

  assign set_p = press[0];
  assign chg_p = press[1];
  assign add_p = press[2];

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [2:0]        fld;
  logic [2:0]        inc_n;
  logic [5:0]        fmask;
  logic [5:0]        mask_n;
  logic              fire;
  logic              mchg;
  logic              hold_clr;
  logic              hold_done;
  logic              phase;
  logic              phase_n;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [HALF_W-1:0] bcnt;
  logic              count_en_q;
  logic [2:0]        inc_q;
  logic [5:0]        mask_q;

  always_comb begin
    fld = 3'b000;
    unique case (state)
      S_HOUR:  fld = 3'b100;
      S_MIN:   fld = 3'b010;
      S_SEC:   fld = 3'b001;
      default: fld = 3'b000;
    endcase
  end

  // first repeat lands when hold completes, then every REP_N
  assign fire = (state != S_RUN) && !deb[2] &&
                (hold_done ? (rep_cnt == REP_LAST)
                           : (hold_cnt == HOLD_LAST));

  always_comb begin
    state_n = state;
    inc_n   = 3'b000;
    if (state == S_RUN) begin
      if (set_p) state_n = S_HOUR;
    end else if (set_p) begin
      state_n = S_RUN;
    end else if (chg_p) begin
      state_n = (state == S_SEC) ? S_HOUR : state + 2'd1;
    end else if (add_p || fire) begin
      inc_n = fld;
    end
  end

  assign mchg     = (state_n != state);
  assign hold_clr = (state == S_RUN) || deb[2] || set_p || chg_p;

  always_ff @(posedge clk) begin
    if (rst || hold_clr) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
      rep_cnt   <= '0;
    end else if (!hold_done) begin
      if (hold_cnt == HOLD_LAST) hold_done <= 1'b1;
      else hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + REP_W'(1);
    end
  end

  // phase restarts on entry so the edited field starts lit
  assign phase_n = mchg ? 1'b0 :
                   (bcnt == HALF_LAST) ? ~phase : phase;

  always_ff @(posedge clk) begin
    if (rst || mchg) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == HALF_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + HALF_W'(1);
    end
  end

  always_comb begin
    fmask = 6'b000000;
    unique case (state_n)
      S_HOUR:  fmask = 6'b110000;
      S_MIN:   fmask = 6'b001100;
      S_SEC:   fmask = 6'b000011;
      default: fmask = 6'b000000;
    endcase
  end

  assign mask_n = fmask & {6{phase_n}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      count_en_q <= 1'b0;
      inc_q      <= 3'b000;
      mask_q     <= 6'b000000;
    end else begin
      state      <= state_n;
      count_en_q <= (state_n == S_RUN);
      inc_q      <= inc_n;
      mask_q     <= mask_n;
    end
  end

  assign bus.mode       = state;
  assign bus.count_en   = count_en_q;
  assign bus.hour_inc   = inc_q[2];
  assign bus.minute_inc = inc_q[1];
  assign bus.second_inc = inc_q[0];
  assign bus.blink_mask = mask_q;

endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed steps with an inc-pulse scoreboard.
// Expected inc pulses are queued at stimulus time and matched by cycle.
module tb_time_set_controller;

  logic clk = 1'b0;
  logic rst;

  time_set_controller_if bus ();

  time_set_controller #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (4),
    .BLINK_HZ    (125),
    .HOLD_MS     (20),
    .REPEAT_HZ   (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [34:0] exp_q [$];
  logic [2:0] incs;

  assign incs = {bus.hour_inc, bus.minute_inc, bus.second_inc};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      0: bus.set_time_button = v;
      1: bus.set_time_change_button = v;
      default: bus.set_time_add_button = v;
    endcase
  endtask

  task automatic expect_inc(input int at, input logic [2:0] kind);
    exp_q.push_back({at[31:0], kind});
  endtask

  // press held 6 cycles; effect lands 7 edges after the drive
  task automatic tap(input int b, input logic [2:0] kind);
    if (kind != 3'b000) expect_inc(cyc + 7, kind);
    drive(b, 1'b0);
    tick(6);
    drive(b, 1'b1);
    tick(8);
  endtask

  always @(negedge clk) begin : mon
    logic [34:0] got;
    logic [34:0] want;
    if (incs != 3'b000) begin
      got = {cyc[31:0], incs};
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL inc_unexp: got cyc %0d incs %b want none",
               cyc, incs);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
          bad++;
          $error("FAIL inc_seq: got cyc %0d incs %b want cyc %0d incs %b",
                 got[34:3], got[2:0], want[34:3], want[2:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    bus.set_time_button        = 1'b1;
    bus.set_time_change_button = 1'b1;
    bus.set_time_add_button    = 1'b1;

    tick(3);
    chk("rst_mode", bus.mode, 0);
    chk("rst_mask", bus.blink_mask, 0);
    chk("rst_inc", incs, 0);
    chk("rst_cen", bus.count_en, 0);
    rst = 1'b0;
    tick(1);
    chk("cen_release", bus.count_en, 1);

    drive(0, 1'b0);
    tick(3);
    drive(0, 1'b1);
    tick(10);
    chk("glitch_mode", bus.mode, 0);

    c = cyc;
    drive(0, 1'b0);
    tick(6);
    chk("lat_early", bus.mode, 0);
    tick(1);
    chk("lat_cyc", cyc - c, 7);
    chk("lat_mode", bus.mode, 1);
    chk("lat_cen", bus.count_en, 0);
    drive(0, 1'b1);
    tick(10);
    tap(0, 3'b000);
    chk("second_press", bus.mode, 0);
    chk("second_cen", bus.count_en, 1);

    tap(0, 3'b000);
    chk("ed_set", bus.mode, 1);
    chk("ed_cen1", bus.count_en, 0);
    tap(2, 3'b100);
    chk("ed_addh", bus.mode, 1);
    tap(1, 3'b000);
    chk("ed_chg1", bus.mode, 2);
    chk("ed_cen2", bus.count_en, 0);
    tap(2, 3'b010);
    chk("ed_addm", bus.mode, 2);
    tap(1, 3'b000);
    chk("ed_chg2", bus.mode, 3);
    tap(2, 3'b001);
    chk("ed_adds", bus.mode, 3);
    chk("ed_cen3", bus.count_en, 0);
    tap(0, 3'b000);
    chk("ed_run", bus.mode, 0);
    chk("ed_cen4", bus.count_en, 1);
    chk("ed_queue", exp_q.size(), 0);

    for (int k = 0; k < 8; k++) begin
      chk("run_mask", bus.blink_mask, 0);
      tick(1);
    end
    tap(0, 3'b000);
    drive(1, 1'b0);
    tick(7);
    chk("blink_mode", bus.mode, 2);
    for (int k = 0; k < 12; k++) begin
      chk("blink", bus.blink_mask,
          ((k / 4) % 2 == 1) ? 6'b001100 : 6'b000000);
      tick(1);
    end
    drive(1, 1'b1);
    tick(8);

    tap(1, 3'b000);
    chk("rep_mode", bus.mode, 3);
    c = cyc;
    expect_inc(c + 7, 3'b001);
    expect_inc(c + 26, 3'b001);
    expect_inc(c + 36, 3'b001);
    expect_inc(c + 46, 3'b001);
    expect_inc(c + 56, 3'b001);
    drive(2, 1'b0);
    tick(50);
    drive(2, 1'b1);
    tick(30);
    chk("rep_queue", exp_q.size(), 0);
    chk("rep_mode2", bus.mode, 3);

    tap(1, 3'b000);
    chk("wrap_hour", bus.mode, 1);
    drive(0, 1'b0);
    drive(2, 1'b0);
    tick(6);
    drive(0, 1'b1);
    drive(2, 1'b1);
    tick(8);
    chk("simul_mode", bus.mode, 0);
    chk("simul_cen", bus.count_en, 1);

    tap(0, 3'b000);
    tap(1, 3'b000);
    chk("pre_rst", bus.mode, 2);
    rst = 1'b1;
    tick(1);
    chk("mrst_mode", bus.mode, 0);
    chk("mrst_cen", bus.count_en, 0);
    chk("mrst_mask", bus.blink_mask, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mrst_cen1", bus.count_en, 1);
    chk("mrst_mode1", bus.mode, 0);
    tick(5);

    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
